modn_updown_counter: RTL and testbench
======================================

MODN_UPDOWN_COUNTER -- requirements
Module: modn_updown_counter

Interface
REQ-001 Parameter N, default 6: modulus; count sequence spans 0..N-1; legal range 2..2^W.
REQ-002 Parameter W, default 3: width of count, load_val.
REQ-003 Port clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-005 Port en  input  1  count enable; count steps by one when high.
REQ-006 Port up_dn  input  1  direction: 1 = up (increment), 0 = down (decrement).
REQ-007 Port load  input  1  synchronous load strobe.
REQ-008 Port load_val  input  W  value for load.
REQ-009 Port count  output  W  current count, registered.
REQ-010 Port tc  output  1  registered wrap pulse.
REQ-011 Port load_err  output  1  registered out-of-range-load pulse.

Function
REQ-012 Per-edge priority: rst > load > en > hold.
REQ-013 en=1, up_dn=1, count<N-1: count <= count+1; tc <= 0.
REQ-014 en=1, up_dn=1, count==N-1: count <= 0; tc <= 1 (up wrap).
REQ-015 en=1, up_dn=0, count>0: count <= count-1; tc <= 0.
REQ-016 en=1, up_dn=0, count==0: count <= N-1; tc <= 1 (down wrap).
REQ-017 tc high exactly one cycle, coincident with the cycle count shows the wrapped value; en=1 in consecutive wrap cycles (N=2) gives tc high on each wrap.
REQ-018 en=0, load=0: count holds; tc <= 0; load_err <= 0.
REQ-019 load=1, load_val<=N-1: count <= load_val; tc <= 0; load_err <= 0; en, up_dn ignored that cycle.
REQ-020 load=1, load_val>=N: count <= N-1 (clamp); load_err <= 1 for one cycle; tc <= 0.
REQ-021 load_err deasserts on the next edge unless another out-of-range load occurs.
REQ-022 up_dn change takes effect on the same edge it is sampled; no turnaround cycle.
REQ-023 Arithmetic internal only; count never holds a value >= N after any edge.
REQ-024 N == 2^W: wrap logic identical; no reliance on natural W-bit overflow.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 rst=1 at edge: count <= 0, tc <= 0, load_err <= 0, regardless of load, en, up_dn.
REQ-027 rst asserted mid-count takes effect on the sampling edge; counting resumes from 0 on the first edge with rst=0 and en=1.
REQ-028 Outputs undefined only before the first reset edge; no asynchronous behaviour.

Verification
REQ-029 N=6: rst, then en=1, up_dn=1 for 7 edges -> count 1,2,3,4,5,0,1; tc high only in the cycle count=0.
REQ-030 N=6: rst, then en=1, up_dn=0 for 7 edges -> count 5,4,3,2,1,0,5; tc high in the cycle count first=5 and again when count returns to 5.
REQ-031 N=6: load=1, load_val=3, en=1 -> count=3, tc=0, load_err=0; next edge load=0, up_dn=0 -> count=2.
REQ-032 N=6: load=1, load_val=7 -> count=5, load_err=1 one cycle; next edge en=0 -> count=5, load_err=0.
REQ-033 N=6: count=4 counting up; rst=1 with load=1, load_val=2 same edge -> count=0, tc=0, load_err=0; hold rst two edges -> count stays 0.
REQ-034 N=6: count=5, up_dn=1 then up_dn=0 on alternate edges with en=1 -> count 0,5,0,5; tc high each cycle; en=0 -> count holds, tc=0.

Source files
------------

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with synchronous load and a registered wrap pulse.
// Loads outside 0..N-1 clamp to N-1 and raise a one-cycle load_err pulse.
// Wrap detection compares against N-1 and 0 explicitly. It never relies on
// natural W-bit overflow, so N == 2^W behaves exactly like any other modulus.
module modn_updown_counter #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         load_err
);

  // Top of the count range. N-1 always fits in W bits because N <= 2^W.
  localparam logic [W-1:0] CNT_MAX = W'(N - 1);

  // The modulus needs one extra bit, so that N == 2^W can still be compared.
  localparam logic [W:0] MODULUS = (W + 1)'(N);

  logic load_oor;

  // A load value is out of range when it is N or more. This is never true
  // when N == 2^W.
  assign load_oor = ({1'b0, load_val} >= MODULUS);

  // Per-edge priority is reset, then load, then count, then hold. Every
  // output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      tc <= 1'b0;
      if (load_oor) begin
        count    <= CNT_MAX;
        load_err <= 1'b1;
      end else begin
        count    <= load_val;
        load_err <= 1'b0;
      end
    end else if (en) begin
      load_err <= 1'b0;
      if (up_dn) begin
        // The >= also pulls a stray value back into range on the next
        // enabled edge.
        if (count >= CNT_MAX) begin
          count <= '0;
          tc    <= 1'b1;
        end else begin
          count <= count + 1'b1;
          tc    <= 1'b0;
        end
      end else begin
        if (count == '0) begin
          count <= CNT_MAX;
          tc    <= 1'b1;
        end else begin
          count <= count - 1'b1;
          tc    <= 1'b0;
        end
      end
    end else begin
      tc       <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter. It drives N=6 and N=8 (== 2^W) instances
// from the same stimulus. Expected values come from a behavioural model,
// are queued when stimulus is applied, and are popped and compared after
// the edge.
module tb_modn_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = '0;

  logic [2:0] count6, count8;
  logic       tc6, tc8, load_err6, load_err8;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int c6; int t6; int e6;
    int c8; int t8; int e8;
  } exp_t;

  exp_t sb[$];

  // Model state for each instance.
  int m6 = 0;
  int m8 = 0;

  always #5 clk = ~clk;

  modn_updown_counter #(.N(6), .W(3)) dut6 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count6), .tc(tc6), .load_err(load_err6)
  );

  modn_updown_counter #(.N(8), .W(3)) dut8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count8), .tc(tc8), .load_err(load_err8)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one edge of a modulus-n counter.
  function automatic void model(input int n, input int m, output int nm,
                                output int t, output int e);
    nm = m; t = 0; e = 0;
    if (rst) begin
      nm = 0;
    end else if (load) begin
      if (int'(load_val) > n - 1) begin
        nm = n - 1; e = 1;
      end else begin
        nm = int'(load_val);
      end
    end else if (en) begin
      if (up_dn) begin
        t  = (m == n - 1) ? 1 : 0;
        nm = (m + 1) % n;
      end else begin
        t  = (m == 0) ? 1 : 0;
        nm = (m + n - 1) % n;
      end
    end
  endfunction

  // Applies one cycle of stimulus, queues the expectation, then compares
  // the outputs after the edge.
  task automatic drive(input logic r_, input logic l_, input logic [2:0] lv_,
                       input logic en_, input logic ud_);
    exp_t e, g;
    @(negedge clk);
    rst = r_; load = l_; load_val = lv_; en = en_; up_dn = ud_;
    model(6, m6, e.c6, e.t6, e.e6);
    model(8, m8, e.c8, e.t8, e.e8);
    m6 = e.c6;
    m8 = e.c8;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      g = sb.pop_front();
      chk("count6", int'(count6), g.c6);
      chk("tc6", int'(tc6), g.t6);
      chk("load_err6", int'(load_err6), g.e6);
      chk("count8", int'(count8), g.c8);
      chk("tc8", int'(tc8), g.t8);
      chk("load_err8", int'(load_err8), g.e8);
    end
  endtask

  initial begin
    // Reset state
    drive(1, 0, 3'd0, 0, 0);
    chk("rst_count6", int'(count6), 0);

    // Count up 7 edges: 1,2,3,4,5,0,1
    for (int i = 0; i < 7; i++) drive(0, 0, 3'd0, 1, 1);
    chk("up_end6", int'(count6), 1);

    // Count down 7 edges from reset: 5,4,3,2,1,0,5
    drive(1, 0, 3'd0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 3'd0, 1, 0);
    chk("dn_end6", int'(count6), 5);

    // In-range load overrides en, then count down
    drive(0, 1, 3'd3, 1, 1);
    drive(0, 0, 3'd0, 1, 0);
    chk("load3_dn6", int'(count6), 2);

    // Boundary in-range and out-of-range loads, then hold
    drive(0, 1, 3'd5, 1, 0);
    drive(0, 1, 3'd6, 0, 0);
    drive(0, 1, 3'd7, 0, 0);
    drive(0, 0, 3'd0, 0, 0);
    chk("clamp_hold6", int'(count6), 5);
    drive(0, 1, 3'd7, 1, 1);
    drive(0, 1, 3'd7, 1, 1);
    drive(0, 1, 3'd0, 1, 1);

    // Reset beats load, held for two edges
    drive(1, 0, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 3'd0, 1, 1);
    drive(1, 1, 3'd2, 1, 1);
    drive(1, 0, 3'd0, 1, 1);
    drive(0, 0, 3'd0, 1, 1);
    chk("resume6", int'(count6), 1);

    // Alternating direction at the top: 0,5,0,5 with tc each edge, then hold
    drive(0, 1, 3'd5, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 3'd0, 1, ((i % 2) == 0) ? 1'b1 : 1'b0);
    drive(0, 0, 3'd0, 0, 1);
    chk("alt_hold6", int'(count6), 5);

    // Random mix
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)));
    end

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
